// File: rtl/digit_scan_ctrl.sv
// Four-digit BCD up/down counter with a time-multiplexed, common-anode style
// digit scanner (guard slot, leading-zero blanking, registered outputs).
module digit_scan_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        inc,
    input  logic        dec,
    output logic [3:0]  digit_out,
    output logic [3:0]  an_n,
    output logic        ovf,
    output logic        err
);

    localparam int          DIV_W    = 16;
    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    typedef enum logic {
        S_GUARD = 1'b0,
        S_SHOW  = 1'b1
    } slot_state_t;

    // ------------------------------------------------------------------
    // BCD helpers
    // ------------------------------------------------------------------
    function automatic logic bcd_valid(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [15:0]      r_count;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_idx;
    slot_state_t      r_state;
    logic [3:0]       r_digit;
    logic [3:0]       r_an_n;
    logic             r_ovf;
    logic             r_err;

    logic [15:0]      w_count_nxt;
    logic             w_ovf_nxt;
    logic             w_err_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic [1:0]       w_idx_nxt;
    slot_state_t      w_state_nxt;
    logic [3:0]       w_digit_nxt;
    logic [3:0]       w_an_nxt;
    logic             w_div_tc;
    logic [3:0]       w_blank;

    // ------------------------------------------------------------------
    // Count update: clr > load > inc/dec
    // ------------------------------------------------------------------
    always_comb begin
        w_count_nxt = r_count;
        w_ovf_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        if (clr) begin
            w_count_nxt = 16'h0000;
        end else if (load) begin
            if (bcd_valid(load_val)) begin
                w_count_nxt = load_val;
            end else begin
                w_err_nxt = 1'b1;
            end
        end else if (inc && !dec) begin
            w_count_nxt = bcd_inc(r_count);
            w_ovf_nxt   = (r_count == 16'h9999);
        end else if (dec && !inc) begin
            w_count_nxt = bcd_dec(r_count);
            w_ovf_nxt   = (r_count == 16'h0000);
        end
    end

    // A digit is blanked only when it and every more significant digit is 0.
    always_comb begin
        w_blank    = 4'b0000;
        w_blank[3] = (BLANK_LZ != 0) && (r_count[15:12] == 4'd0);
        w_blank[2] = w_blank[3] && (r_count[11:8] == 4'd0);
        w_blank[1] = w_blank[2] && (r_count[7:4] == 4'd0);
    end

    always_comb begin
        w_digit_nxt = r_count[3:0];
        case (r_idx)
            2'd0: w_digit_nxt = r_count[3:0];
            2'd1: w_digit_nxt = r_count[7:4];
            2'd2: w_digit_nxt = r_count[11:8];
            2'd3: w_digit_nxt = r_count[15:12];
            default: w_digit_nxt = r_count[3:0];
        endcase
    end

    // ------------------------------------------------------------------
    // Slot FSM: one GUARD cycle (divider 0) then SHOW for the rest.
    // ------------------------------------------------------------------
    assign w_div_tc = (r_div == DIV_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div + 16'd1;
        w_idx_nxt   = r_idx;
        w_an_nxt    = 4'b1111;
        if (w_div_tc) begin
            w_div_nxt   = '0;
            w_idx_nxt   = r_idx + 2'd1;
            w_state_nxt = S_GUARD;
        end else begin
            w_state_nxt = S_SHOW;
        end
        case (r_state)
            S_GUARD: w_an_nxt = 4'b1111;
            S_SHOW: begin
                if (!w_blank[r_idx]) w_an_nxt = ~(4'b0001 << r_idx);
            end
            default: w_an_nxt = 4'b1111;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_GUARD;
            r_div   <= '0;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 16'h0000;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
            r_digit <= 4'h0;
            r_an_n  <= 4'b1111;
        end else begin
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
            r_err   <= w_err_nxt;
            r_digit <= w_digit_nxt;
            r_an_n  <= w_an_nxt;
        end
    end

    assign digit_out = r_digit;
    assign an_n      = r_an_n;
    assign ovf       = r_ovf;
    assign err       = r_err;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with SCAN_DIV=4, BLANK_LZ=1: scan frames,
// BCD carry/borrow, wrap pulses, load rejection, priority and async reset.
module tb_digit_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic        inc = 1'b0;
    logic        dec = 1'b0;
    logic [3:0]  digit_out;
    logic [3:0]  an_n;
    logic        ovf;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    digit_scan_ctrl #(
        .SCAN_DIV(4),
        .BLANK_LZ(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .inc      (inc),
        .dec      (dec),
        .digit_out(digit_out),
        .an_n     (an_n),
        .ovf      (ovf),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One-cycle request, then check the pulse flags on the following two samples.
    task automatic pulse(input string tag, input logic c, input logic l, input logic [15:0] lv,
                         input logic i, input logic d, input logic e_ovf, input logic e_err);
        clr = c; load = l; load_val = lv; inc = i; dec = d;
        tick();
        clr = 1'b0; load = 1'b0; inc = 1'b0; dec = 1'b0;
        chk({tag, "_ovf"}, 16'(ovf), 16'(e_ovf));
        chk({tag, "_err"}, 16'(err), 16'(e_err));
        tick();
        chk({tag, "_ovf_end"}, 16'(ovf), 16'h0);
        chk({tag, "_err_end"}, 16'(err), 16'h0);
    endtask

    // Align to a frame start, then check 16 cycles: per slot one guard cycle
    // (an_n=1111) and three show cycles. an_show/digits hold one nibble per slot.
    task automatic check_frame(input string tag, input logic [15:0] an_show, input logic [15:0] digits);
        while ((cyc % 16) != 0) tick();
        for (int s = 0; s < 4; s++) begin
            for (int d = 0; d < 4; d++) begin
                tick();
                chk($sformatf("%s_an_s%0d_c%0d", tag, s, d), 16'(an_n),
                    (d == 0) ? 16'h000F : 16'(an_show[4*s +: 4]));
                chk($sformatf("%s_dig_s%0d_c%0d", tag, s, d), 16'(digit_out),
                    16'(digits[4*s +: 4]));
            end
        end
    endtask

    initial begin
        // Reset held across a few clock edges
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", 16'(an_n), 16'h000F);
        chk("rst_dig", 16'(digit_out), 16'h0);
        chk("rst_ovf", 16'(ovf), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        rst_n = 1'b1;
        cyc = 0;

        // Idle after reset: slot 0 shows 0, slots 1..3 blanked
        check_frame("lz0", 16'hFFFE, 16'h0000);

        pulse("ld1234", 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
        check_frame("f1234", 16'h7BDE, 16'h1234);

        pulse("ld9999", 1'b0, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b0);
        check_frame("f9999", 16'h7BDE, 16'h9999);
        pulse("inc_wrap", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        check_frame("f0000", 16'hFFFE, 16'h0000);
        pulse("dec_wrap", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
        check_frame("f9999b", 16'h7BDE, 16'h9999);

        // Rejected load leaves the count alone
        pulse("ld_bad", 1'b0, 1'b1, 16'h12A4, 1'b0, 1'b0, 1'b0, 1'b1);
        check_frame("f9999c", 16'h7BDE, 16'h9999);

        // clr wins over load and inc
        pulse("prio", 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
        check_frame("fclr", 16'hFFFE, 16'h0000);

        pulse("ld0099", 1'b0, 1'b1, 16'h0099, 1'b0, 1'b0, 1'b0, 1'b0);
        check_frame("f0099", 16'hFFDE, 16'h0099);
        pulse("incdec", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        check_frame("f0099b", 16'hFFDE, 16'h0099);
        pulse("inc_carry", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        check_frame("f0100", 16'hFBDE, 16'h0100);
        pulse("dec_borrow", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        check_frame("f0099c", 16'hFFDE, 16'h0099);

        // Async reset in the middle of slot 2's SHOW phase
        pulse("ld1234b", 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
        while ((cyc % 16) != 0) tick();
        repeat (10) tick();
        chk("mid_an", 16'(an_n), 16'h000B);
        chk("mid_dig", 16'(digit_out), 16'h2);
        rst_n = 1'b0;
        #1;
        chk("async_an", 16'(an_n), 16'h000F);
        chk("async_dig", 16'(digit_out), 16'h0);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        tick();
        chk("post_rst_an", 16'(an_n), 16'h000F);
        chk("post_rst_dig", 16'(digit_out), 16'h0);
        check_frame("fpost", 16'hFFFE, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/digit_scan_ctrl.md
DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000, SHALL set the clock cycles per digit slot (legal range 2..65535).
REQ-002 Parameter BLANK_LZ, default 1, SHALL enable leading-zero blanking when 1.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the reset, asynchronous, active-low.
REQ-005 Port clr, input, 1 bit, SHALL be a synchronous clear of the count.
REQ-006 Port load, input, 1 bit, SHALL be a load strobe for load_val.
REQ-007 Port load_val, input, 16 bits, SHALL be four BCD digits; [3:0] is digit 0 (ones) and [15:12] is digit 3 (thousands).
REQ-008 Port inc, input, 1 bit, SHALL request count +1 in that cycle.
REQ-009 Port dec, input, 1 bit, SHALL request count -1 in that cycle.
REQ-010 Port digit_out, output, 4 bits, SHALL carry the BCD code of the active digit to the segment decoder input.
REQ-011 Port an_n, output, 4 bits, SHALL be active-low one-hot digit enables; bit k enables digit k.
REQ-012 Port ovf, output, 1 bit, SHALL be a one-cycle pulse on wrap 9999->0000 or 0000->9999.
REQ-013 Port err, output, 1 bit, SHALL be a one-cycle pulse when a load is rejected.

Function
REQ-014 The count SHALL be four BCD digits (0000..9999); no digit SHALL ever hold a value above 9.
REQ-015 Per-cycle priority SHALL be clr > load > inc/dec; a lower-priority request in the same cycle SHALL be ignored.
REQ-016 On clr, the count SHALL become 0000 next cycle.
REQ-017 On load, if every load_val nibble is <=9, the count SHALL become load_val next cycle; otherwise the count SHALL be unchanged and err SHALL pulse next cycle.
REQ-018 On inc alone, the count SHALL increment with decimal carry (0099->0100); 9999 SHALL wrap to 0000 with ovf pulsed next cycle.
REQ-019 On dec alone, the count SHALL decrement with decimal borrow (0100->0099); 0000 SHALL wrap to 9999 with ovf pulsed next cycle.
REQ-020 On inc and dec together, the count SHALL be unchanged and ovf SHALL stay 0.
REQ-021 The scan divider SHALL count 0..SCAN_DIV-1; at terminal count, slot index SHALL advance 0->1->2->3->0 and the divider SHALL return to 0.
REQ-022 Slot state machine per slot: GUARD for divider value 0, then SHOW for divider values 1..SCAN_DIV-1.
REQ-023 In GUARD, an_n SHALL be 4'b1111 (anti-ghosting dead time).
REQ-024 In SHOW, an_n SHALL drive bit[index] low and all other bits high, unless the digit is blanked.
REQ-025 If BLANK_LZ=1, digit k (k=3,2,1) SHALL be blanked when it and all higher digits are 0; digit 0 SHALL never be blanked; a blanked slot SHALL keep an_n=4'b1111.
REQ-026 digit_out and an_n SHALL be registered; they SHALL reflect the count and index held in the previous cycle (1-cycle latency).
REQ-027 digit_out SHALL equal the count digit selected by index, including during GUARD and blanked slots.
REQ-028 Count updates SHALL NOT reset or stall the scan divider or the slot index.

Reset
REQ-029 While rst_n=0, regardless of clk: count=0000, index=0, divider=0, digit_out=4'h0, an_n=4'b1111, ovf=0, err=0.
REQ-030 After rst_n deasserts, the first rising edge SHALL begin slot 0 in GUARD; reset asserted mid-slot SHALL abort the slot immediately.

Verification (SCAN_DIV=4, BLANK_LZ=1 unless stated)
REQ-031 Reset release, no inputs -> an_n=1111 for 1 cycle, then 1110 for 3 cycles with digit_out=0; the 1111 slots of digits 1..3 are blanked.
REQ-032 load 16'h1234, then scan for 16 cycles -> per slot: 1 cycle of an_n=1111, then 3 cycles of 1110/1101/1011/0111 with digit_out 4/3/2/1.
REQ-033 load 16'h9999, then inc -> count 0000, ovf=1 for exactly 1 cycle; a following dec -> count 9999, ovf=1 again.
REQ-034 load 16'h12A4 -> err=1 for 1 cycle and count unchanged; clr+load+inc in the same cycle -> count 0000 with no err or ovf.
REQ-035 Count 0099, inc and dec together -> 0099 held; inc alone -> 0100, and digit 2 is no longer blanked.
REQ-036 rst_n pulsed low mid-SHOW of slot 2 -> an_n=1111 and digit_out=0 asynchronously; count reads 0000 after release.
